// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: request and result handshake bundle for mux_sel_pipe
interface mux_sel_pipe_if #(
  parameter int NR_CH = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W = 2
);
  logic in_valid;
  logic in_ready;
  logic [NR_CH*DATA_W-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic mode;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0] out_ch;
  logic out_hit;
  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input in_ready, out_valid, out_data, out_ch, out_hit
  );
  modport slave (
    input in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_hit
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered valid/ready lane selector (direct or round-robin scan) with default path.
// Defining MUX_SEL_PIPE_MISS_CNT_EN adds a saturating out-of-range miss counter port.
module mux_sel_pipe #(
  parameter int NR_CH = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W = 2,
  parameter logic [DATA_W-1:0] DEF_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  mux_sel_pipe_if.slave bus
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
  ,
  output logic [7:0] miss_cnt
`endif
);
  logic accept;
  logic hit;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic [DATA_W-1:0] sel_data;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign idx = bus.mode ? ptr : bus.in_sel;
  assign hit = int'(idx) < NR_CH;
  always_comb begin
    sel_data = DEF_VAL;
    for (int i = 0; i < NR_CH; i++)
      if (int'(idx) == i) sel_data = bus.in_data[DATA_W*i +: DATA_W];
  end
  // direct mode parks the pointer at lane 0 so each scan restarts there
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (!bus.mode) ptr <= '0;
    else if (accept) ptr <= (int'(ptr) == NR_CH - 1) ? '0 : ptr + SEL_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      bus.out_hit <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= sel_data;
      bus.out_ch <= idx;
      bus.out_hit <= hit;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) miss_cnt <= '0;
    else if (accept && !hit && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_mux_sel_pipe;
  typedef struct {
    logic [7:0] d;
    logic [2:0] c;
    logic h;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  int exp_miss = 0;
  exp_t exp_q[$];
  mux_sel_pipe_if #(.NR_CH(4), .DATA_W(8), .SEL_W(3)) bus ();
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
  logic [7:0] miss_cnt;
`endif
  mux_sel_pipe #(.NR_CH(4), .DATA_W(8), .SEL_W(3), .DEF_VAL(8'h5A)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    ,
    .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic [2:0] s, input logic m,
                      input logic [7:0] ed, input logic [2:0] ec, input logic eh);
    exp_t e;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_sel = s;
    bus.mode = m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
      bus.in_valid = 1'b0;
      return;
    end
    e.d = ed;
    e.c = ec;
    e.h = eh;
    exp_q.push_back(e);
    if (!eh) exp_miss = (exp_miss == 255) ? 255 : exp_miss + 1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: data=%0h ch=%0h with nothing expected", bus.out_data, bus.out_ch);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_ch", 32'(bus.out_ch), 32'(e.c));
          chk("out_hit", 32'(bus.out_hit), 32'(e.h));
        end
      end
    end
  end
  initial begin
    logic [31:0] dk;
    logic [31:0] ds;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_sel = '0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_hit", 32'(bus.out_hit), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
`endif
    idle(2);
    rst_n = 1'b1;
    // direct selection
    dk = 32'hDDCC_BBAA;
    send(dk, 3'd2, 1'b0, 8'hCC, 3'd2, 1'b1);
    send(dk, 3'd0, 1'b0, 8'hAA, 3'd0, 1'b1);
    send(dk, 3'd3, 1'b0, 8'hDD, 3'd3, 1'b1);
    // out-of-range codes take the default path
    send(dk, 3'd5, 1'b0, 8'h5A, 3'd5, 1'b0);
    idle(2);
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    chk("miss_cnt_first", 32'(miss_cnt), 1);
`endif
    send(dk, 3'd4, 1'b0, 8'h5A, 3'd4, 1'b0);
    send(dk, 3'd7, 1'b0, 8'h5A, 3'd7, 1'b0);
    // round-robin scan, back to back
    ds = 32'h4433_2211;
    send(ds, 3'd3, 1'b1, 8'h11, 3'd0, 1'b1);
    send(ds, 3'd3, 1'b1, 8'h22, 3'd1, 1'b1);
    send(ds, 3'd3, 1'b1, 8'h33, 3'd2, 1'b1);
    send(ds, 3'd3, 1'b1, 8'h44, 3'd3, 1'b1);
    send(ds, 3'd3, 1'b1, 8'h11, 3'd0, 1'b1);
    send(ds, 3'd3, 1'b1, 8'h22, 3'd1, 1'b1);
    bus.mode = 1'b0;
    idle(1);
    send(ds, 3'd3, 1'b1, 8'h11, 3'd0, 1'b1);
    idle(1);
    // backpressure
    bus.out_ready = 1'b0;
    send(32'h0000_7700, 3'd1, 1'b0, 8'h77, 3'd1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'h1111_1111 * i;
      bus.in_sel = 3'd1;
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_out_data", 32'(bus.out_data), 32'h77);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(32'h0000_9900, 3'd1, 1'b0, 8'h99, 3'd1, 1'b1);
    chk("no_bubble_valid", 32'(bus.out_valid), 1);
    chk("no_bubble_data", 32'(bus.out_data), 32'h99);
    idle(1);
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_data_kept", 32'(bus.out_data), 32'h99);
    // async reset while a scan result is stalled
    bus.out_ready = 1'b0;
    send(ds, 3'd6, 1'b1, 8'h11, 3'd0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_hit", 32'(bus.out_hit), 0);
    chk("async_rst_ch", 32'(bus.out_ch), 0);
    exp_q.delete();
    exp_miss = 0;
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    chk("async_rst_miss", 32'(miss_cnt), 0);
`endif
    idle(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(ds, 3'd6, 1'b1, 8'h11, 3'd0, 1'b1);
    // long run of misses to saturate the counter
    for (int i = 0; i < 300; i++) send(dk, 3'd6, 1'b0, 8'h5A, 3'd6, 1'b0);
    idle(2);
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    chk("miss_cnt_sat", 32'(miss_cnt), 32'(exp_miss));
`endif
    send(dk, 3'd4, 1'b0, 8'h5A, 3'd4, 1'b0);
    idle(2);
`ifdef MUX_SEL_PIPE_MISS_CNT_EN
    chk("miss_cnt_hold", 32'(miss_cnt), 32'hFF);
`endif
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
